pc_unit: RTL and testbench

- Parametrised fetch-stage program counter; next generation of the single-cycle PC register.
- Selects the next PC from five sources: sequential, branch/JAL, JR, trap vector, return-address-stack (RAS) pop.
- Adds fetch stall, a configurable reset vector, target alignment checking with trap redirect, and an internal RAS for call/return.
- Sits between the control unit (which drives pc_sel) and instruction memory (which consumes pc).

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_unit_ras_stack.sv | 54 +++++
 rtl/pc_unit.sv | 83 ++++++++
 tb/tb_pc_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_JR   = 3'd2,
    PC_TRAP = 3'd3,
    PC_RET  = 3'd4
  } pc_sel_t;

  localparam int XLEN_DEF = 32;
  localparam int STEP_DEF = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control/fetch bus between the control unit, the PC unit and instruction memory.
interface pc_unit_if import pc_pkg::*; #(
  parameter int XLEN      = XLEN_DEF,
  parameter int RAS_DEPTH = 8
) ();
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            stall;
  pc_sel_t         pc_sel;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] trap_vector;
  logic            ras_push;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_step;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;
  logic [CW-1:0]   ras_count;

  modport master (
    output stall, pc_sel, br_target, jr_target, trap_vector, ras_push,
    input  pc, pc_plus_step, misalign, ras_empty, ras_full, ras_count
  );

  modport slave (
    input  stall, pc_sel, br_target, jr_target, trap_vector, ras_push,
    output pc, pc_plus_step, misalign, ras_empty, ras_full, ras_count
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a full push overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic [CW-1:0]   count
);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic            pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(RAS_DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop && !empty;
  assign top_idx = ptr_reg - PW'(1);
  assign top     = mem[top_idx];
  // A simultaneous pop+push replaces the popped slot in place.
  assign wr_idx  = pop_ok ? top_idx : ptr_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push && !pop_ok) begin
      ptr_reg <= ptr_reg + PW'(1);
      if (!full) begin
        count_reg <= count_reg + CW'(1);
      end
    end else if (pop_ok && !push) begin
      ptr_reg   <= top_idx;
      count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC: five-way next-PC select, stall, alignment trap and call/return stack.
module pc_unit import pc_pkg::*; #(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = STEP_DEF,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 8
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic [XLEN-1:0] pc_reg;
  logic            misalign_reg;
  logic [XLEN-1:0] pc_plus_step;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;
  logic            checked;
  logic            misaligned;
  logic            advance;
  logic            push_en;
  logic            pop_en;

  assign pc_plus_step     = pc_reg + XLEN'(STEP);
  assign bus.pc           = pc_reg;
  assign bus.pc_plus_step = pc_plus_step;
  assign bus.misalign     = misalign_reg;

  always_comb begin
    target  = pc_plus_step;
    checked = 1'b0;
    case (bus.pc_sel)
      PC_BR: begin
        target  = bus.br_target;
        checked = 1'b1;
      end
      PC_JR: begin
        target  = bus.jr_target;
        checked = 1'b1;
      end
      PC_TRAP: target = bus.trap_vector;
      PC_RET: begin
        target  = bus.ras_empty ? bus.jr_target : ras_top;
        checked = 1'b1;
      end
      default: target = pc_plus_step;
    endcase
  end

  assign misaligned = checked && ((target & ALIGN_MASK) != '0);
  assign advance    = rst && !bus.stall && !misaligned;
  assign push_en    = advance && bus.ras_push && (bus.pc_sel != PC_TRAP);
  assign pop_en     = advance && (bus.pc_sel == PC_RET);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .pop       (pop_en),
    .push_data (pc_plus_step),
    .top       (ras_top),
    .empty     (bus.ras_empty),
    .full      (bus.ras_full),
    .count     (bus.ras_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= RESET_VECTOR;
      misalign_reg <= 1'b0;
    end else if (bus.stall) begin
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= misaligned ? bus.trap_vector : target;
      misalign_reg <= misaligned;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus hand-written RAS, wrap and reset sequences.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h100),
    .STEP         (4),
    .ALIGN_BITS   (2),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        stall;
    pc_sel_t     sel;
    logic [31:0] br;
    logic [31:0] jr;
    logic [31:0] tv;
    logic        push;
    logic [31:0] exp_pc;
    logic        exp_mis;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        mis;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic st, input pc_sel_t sel, input logic [31:0] br,
                              input logic [31:0] jr, input logic [31:0] tv, input logic push,
                              input logic [31:0] epc, input logic emis, input int ecnt);
    vec_t v;
    v.stall = st; v.sel = sel; v.br = br; v.jr = jr; v.tv = tv; v.push = push;
    v.exp_pc = epc; v.exp_mis = emis; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_underflow: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    $display("[%s] pc=%h mis=%b cnt=%0d empty=%b full=%b", e.tag, bus.pc, bus.misalign,
             bus.ras_count, bus.ras_empty, bus.ras_full);
    if (bus.pc !== e.pc) begin
      n_bad++;
      $display("FAIL %s pc: got %h want %h", e.tag, bus.pc, e.pc);
    end
    if (bus.misalign !== e.mis) begin
      n_bad++;
      $display("FAIL %s misalign: got %b want %b", e.tag, bus.misalign, e.mis);
    end
    if (int'(bus.ras_count) != e.cnt || $isunknown(bus.ras_count)) begin
      n_bad++;
      $display("FAIL %s ras_count: got %0d want %0d", e.tag, bus.ras_count, e.cnt);
    end
    if (bus.ras_empty !== (e.cnt == 0)) begin
      n_bad++;
      $display("FAIL %s ras_empty: got %b want %b", e.tag, bus.ras_empty, e.cnt == 0);
    end
    if (bus.ras_full !== (e.cnt == DEPTH)) begin
      n_bad++;
      $display("FAIL %s ras_full: got %b want %b", e.tag, bus.ras_full, e.cnt == DEPTH);
    end
  endtask

  task automatic apply(input logic rstv, input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst             = rstv;
    bus.stall       = v.stall;
    bus.pc_sel      = v.sel;
    bus.br_target   = v.br;
    bus.jr_target   = v.jr;
    bus.trap_vector = v.tv;
    bus.ras_push    = v.push;
    e.tag = tag; e.pc = v.exp_pc; e.mis = v.exp_mis; e.cnt = v.exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  logic [31:0] links[9];
  logic [31:0] cur;
  pc_sel_t     bad_sel;

  initial begin
    bus.stall = 1'b0; bus.pc_sel = PC_SEQ; bus.br_target = '0; bus.jr_target = '0;
    bus.trap_vector = '0; bus.ras_push = 1'b0;
    bad_sel = pc_sel_t'(3'd5);

    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h104, 0, 0));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h108, 0, 0));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h10C, 0, 0));
    vecs.push_back(mk(0, PC_BR,   32'h200, 0,       0,     0, 32'h200, 0, 0));
    vecs.push_back(mk(0, PC_BR,   32'h400, 0,       0,     1, 32'h400, 0, 1));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h404, 0, 1));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h408, 0, 1));
    vecs.push_back(mk(0, PC_RET,  0,       32'h999, 0,     0, 32'h204, 0, 0));
    vecs.push_back(mk(0, PC_JR,   0,       32'h302, 32'h80, 0, 32'h80, 1, 0));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       32'h80, 0, 32'h84, 0, 0));
    vecs.push_back(mk(0, PC_JR,   0,       32'h301, 32'h80, 1, 32'h80, 1, 0));
    vecs.push_back(mk(0, PC_TRAP, 0,       0,       32'hC0, 1, 32'hC0, 0, 0));
    vecs.push_back(mk(0, PC_RET,  0,       32'h600, 32'h80, 0, 32'h600, 0, 0));
    vecs.push_back(mk(0, PC_RET,  0,       32'h602, 32'h80, 0, 32'h80, 1, 0));
    vecs.push_back(mk(0, bad_sel, 32'h44,  32'h48,  32'h4C, 0, 32'h84, 0, 0));
    vecs.push_back(mk(0, PC_BR,   32'h700, 0,       0,     1, 32'h700, 0, 1));
    vecs.push_back(mk(0, PC_RET,  0,       32'h900, 0,     1, 32'h88,  0, 1));
    vecs.push_back(mk(0, PC_RET,  0,       32'h900, 0,     0, 32'h704, 0, 0));
    vecs.push_back(mk(0, PC_RET,  0,       32'h900, 0,     1, 32'h900, 0, 1));
    vecs.push_back(mk(0, PC_RET,  0,       32'h904, 0,     0, 32'h708, 0, 0));
    vecs.push_back(mk(1, PC_BR,   32'h1000, 0,      0,     1, 32'h708, 0, 0));
    vecs.push_back(mk(1, PC_BR,   32'h1000, 0,      0,     1, 32'h708, 0, 0));
    vecs.push_back(mk(1, PC_BR,   32'h1000, 0,      0,     1, 32'h708, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0,       32'h302, 32'h80, 0, 32'h708, 0, 0));
    vecs.push_back(mk(0, PC_BR,   32'h1000, 0,      0,     1, 32'h1000, 0, 1));
    vecs.push_back(mk(0, PC_SEQ,  0,       0,       0,     0, 32'h1004, 0, 1));
    vecs.push_back(mk(0, PC_RET,  0,       32'h980, 0,     0, 32'h70C, 0, 0));

    // Reset held over two edges, with stall and a redirect pending.
    apply(1'b0, mk(1, PC_BR, 32'h400, 0, 0, 1, 32'h100, 0, 0), "reset0");
    apply(1'b0, mk(0, PC_BR, 32'h400, 0, 0, 1, 32'h100, 0, 0), "reset1");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b1, vecs[i], $sformatf("vec%0d", i));
    end

    // Nine calls into an eight-deep stack, then nine returns.
    cur = 32'h70C;
    for (int i = 0; i < 9; i++) begin
      links[i] = cur + 32'd4;
      cur = 32'h2000 + 32'(i) * 32'h100;
      apply(1'b1, mk(0, PC_BR, cur, 0, 0, 1, cur, 0, (i + 1 > DEPTH) ? DEPTH : i + 1),
            $sformatf("push%0d", i + 1));
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) apply(1'b1, mk(0, PC_RET, 0, 32'h500, 0, 0, links[8 - i], 0, 7 - i),
                       $sformatf("ret%0d", i + 1));
      else       apply(1'b1, mk(0, PC_RET, 0, 32'h500, 0, 0, 32'h500, 0, 0),
                       $sformatf("ret%0d", i + 1));
    end

    // Address wrap at the top of the space.
    apply(1'b1, mk(0, PC_BR,  32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0), "wrap_br");
    apply(1'b1, mk(0, PC_SEQ, 0, 0, 0, 0, 32'h0, 0, 0), "wrap_seq");

    // Reset in the middle of a populated stack discards it.
    apply(1'b1, mk(0, PC_BR, 32'h3000, 0, 0, 1, 32'h3000, 0, 1), "mid_push1");
    apply(1'b1, mk(0, PC_BR, 32'h3100, 0, 0, 1, 32'h3100, 0, 2), "mid_push2");
    apply(1'b1, mk(0, PC_BR, 32'h3200, 0, 0, 1, 32'h3200, 0, 3), "mid_push3");
    apply(1'b0, mk(1, PC_BR, 32'h4000, 0, 0, 1, 32'h100, 0, 0), "mid_reset");
    apply(1'b1, mk(0, PC_RET, 0, 32'h540, 0, 0, 32'h540, 0, 0), "post_reset_ret");

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
